// File: rtl/mmss_timer.sv
// BCD minutes:seconds stopwatch / countdown timer driven by an edge-detected slow
// time base; exposes the count plus running/done status for the display stage.
module mmss_timer #(
    parameter int MIN_MAX      = 59,
    parameter bit TICK_ON_BOTH = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_src,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        mode,
    output logic [15:0] bcd,
    output logic        tick,
    output logic        running,
    output logic        done
);

    localparam logic [7:0] MIN_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state, next_state;
    logic        tick_q;
    logic [15:0] bcd_next, up_val, down_val;
    logic        load_ok, start_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_q <= 1'b0;
        else     tick_q <= tick_src;
    end

    assign tick = TICK_ON_BOTH ? (tick_src ^ tick_q) : (tick_src & ~tick_q);

    // Minutes compare as an 8-bit BCD byte once both digits are known to be decimal.
    assign load_ok = (load_val[3:0] <= 4'd9) && (load_val[7:4] <= 4'd5) &&
                     (load_val[11:8] <= 4'd9) && (load_val[15:12] <= 4'd9) &&
                     (load_val[15:8] <= MIN_BCD);
    assign start_ok = !(mode && (bcd == 16'h0000));

    always_comb begin
        up_val = bcd;
        if (bcd[15:8] == MIN_BCD && bcd[7:0] == 8'h59) begin
            up_val = 16'h0000;
        end else if (bcd[3:0] != 4'd9) begin
            up_val[3:0] = bcd[3:0] + 4'd1;
        end else begin
            up_val[3:0] = 4'd0;
            if (bcd[7:4] != 4'd5) begin
                up_val[7:4] = bcd[7:4] + 4'd1;
            end else begin
                up_val[7:4] = 4'd0;
                if (bcd[11:8] != 4'd9) begin
                    up_val[11:8] = bcd[11:8] + 4'd1;
                end else begin
                    up_val[11:8]  = 4'd0;
                    up_val[15:12] = bcd[15:12] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        down_val = bcd;
        if (bcd == 16'h0000) begin
            down_val = 16'h0000;
        end else if (bcd[3:0] != 4'd0) begin
            down_val[3:0] = bcd[3:0] - 4'd1;
        end else begin
            down_val[3:0] = 4'd9;
            if (bcd[7:4] != 4'd0) begin
                down_val[7:4] = bcd[7:4] - 4'd1;
            end else begin
                down_val[7:4] = 4'd5;
                if (bcd[11:8] != 4'd0) begin
                    down_val[11:8] = bcd[11:8] - 4'd1;
                end else begin
                    down_val[11:8]  = 4'd9;
                    down_val[15:12] = bcd[15:12] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        // NOTE: both outputs get a default first so no branch can infer a latch.
        next_state = state;
        bcd_next   = bcd;
        case (state)
            IDLE, PAUSE: begin
                if (clear) begin
                    next_state = IDLE;
                    bcd_next   = 16'h0000;
                end else if (stop) begin
                    next_state = state;
                end else if (start) begin
                    if (start_ok) next_state = RUN;
                end else if (load && load_ok) begin
                    bcd_next = load_val;
                end
            end
            RUN: begin
                if (clear) begin
                    next_state = IDLE;
                    bcd_next   = 16'h0000;
                end else begin
                    if (tick) bcd_next = mode ? down_val : up_val;
                    // Reaching zero wins over a same-edge stop.
                    if (tick && mode && down_val == 16'h0000) next_state = DONE;
                    else if (stop)                             next_state = PAUSE;
                end
            end
            DONE: begin
                if (clear) begin
                    next_state = IDLE;
                    bcd_next   = 16'h0000;
                end else if (stop) begin
                    next_state = DONE;
                end else if (start) begin
                    next_state = IDLE;
                end else if (load) begin
                    next_state = IDLE;
                    if (load_ok) bcd_next = load_val;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bcd     <= 16'h0000;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            bcd     <= bcd_next;
            running <= (next_state == RUN);
            done    <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_mmss_timer.sv
// Self-checking bench for mmss_timer: directed scenarios plus a randomized run against
// a total-seconds reference model, on rising-edge and both-edge instances.
module tb_mmss_timer;

    localparam int MIN_MAX = 59;
    localparam int MAX_T   = MIN_MAX * 60 + 59;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        rst, tick_src, start, stop, clear, load, mode;
    logic [15:0] load_val;
    logic [15:0] bcd_a, bcd_b;
    logic        tick_a, tick_b, running_a, running_b, done_a, done_b;

    int n_pass  = 0;
    int n_total = 0;

    int   m_state[2];
    int   m_total[2];
    logic src_last;

    mmss_timer #(.MIN_MAX(MIN_MAX), .TICK_ON_BOTH(1'b0)) dut (
        .clk(clk), .rst(rst), .tick_src(tick_src), .start(start), .stop(stop),
        .clear(clear), .load(load), .load_val(load_val), .mode(mode),
        .bcd(bcd_a), .tick(tick_a), .running(running_a), .done(done_a)
    );

    mmss_timer #(.MIN_MAX(MIN_MAX), .TICK_ON_BOTH(1'b1)) dut_b (
        .clk(clk), .rst(rst), .tick_src(tick_src), .start(start), .stop(stop),
        .clear(clear), .load(load), .load_val(load_val), .mode(mode),
        .bcd(bcd_b), .tick(tick_b), .running(running_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load = 1'b1; load_val = v; clk1(); load = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1; clk1(); start = 1'b0;
    endtask

    task automatic pulse_clear;
        clear = 1'b1; clk1(); clear = 1'b0;
    endtask

    // One rising edge of tick_src, ending with tick_src high.
    task automatic rise_tick;
        if (tick_src) begin
            tick_src = 1'b0; clk1();
        end
        tick_src = 1'b1; clk1();
    endtask

    function automatic bit valid_bcd(input logic [15:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5) && (v[11:8] <= 4'd9) &&
               (v[15:12] <= 4'd9) && (int'(v[15:12]) * 10 + int'(v[11:8]) <= MIN_MAX);
    endfunction

    function automatic int to_total(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step(input int k, input bit ev);
        case (m_state[k])
            S_IDLE, S_PAUSE: begin
                if (clear) begin
                    m_state[k] = S_IDLE; m_total[k] = 0;
                end else if (!stop) begin
                    if (start) begin
                        if (!(mode && m_total[k] == 0)) m_state[k] = S_RUN;
                    end else if (load && valid_bcd(load_val)) begin
                        m_total[k] = to_total(load_val);
                    end
                end
            end
            S_RUN: begin
                if (clear) begin
                    m_state[k] = S_IDLE; m_total[k] = 0;
                end else begin
                    if (ev) begin
                        if (mode) begin
                            if (m_total[k] <= 1) begin
                                m_total[k] = 0; m_state[k] = S_DONE;
                            end else m_total[k] = m_total[k] - 1;
                        end else begin
                            m_total[k] = (m_total[k] == MAX_T) ? 0 : m_total[k] + 1;
                        end
                    end
                    if (stop && m_state[k] == S_RUN) m_state[k] = S_PAUSE;
                end
            end
            default: begin
                if (clear) begin
                    m_state[k] = S_IDLE; m_total[k] = 0;
                end else if (!stop) begin
                    if (start) m_state[k] = S_IDLE;
                    else if (load) begin
                        m_state[k] = S_IDLE;
                        if (valid_bcd(load_val)) m_total[k] = to_total(load_val);
                    end
                end
            end
        endcase
    endtask

    task automatic test_reset;
        rst = 1'b1; tick_src = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        load = 1'b0; load_val = 16'h0000; mode = 1'b0;
        #3;
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_init: got %h expected %h", {bcd_a, running_a, done_a}, 18'h0);
        else n_pass++;
        #20 rst = 1'b0;
        clk1();
        pulse_load(16'h0100);
        pulse_start();
        rise_tick();
        n_total++;
        if ({bcd_a, running_a} !== {16'h0101, 1'b1})
            $display("FAIL reset_prerun: got %h expected %h", {bcd_a, running_a}, {16'h0101, 1'b1});
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_async: got %h expected %h", {bcd_a, running_a, done_a}, 18'h0);
        else n_pass++;
        #1 rst = 1'b0;
        clk1();
    endtask

    task automatic test_up_wrap;
        mode = 1'b0;
        pulse_load(16'h5958);
        pulse_start();
        tick_src = 1'b0; clk1();
        tick_src = 1'b1; #1;
        n_total++;
        if ({tick_a, bcd_a} !== {1'b1, 16'h5958})
            $display("FAIL up_latency: got %h expected %h", {tick_a, bcd_a}, {1'b1, 16'h5958});
        else n_pass++;
        clk1();
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h5959, 1'b1, 1'b0})
            $display("FAIL up_5959: got %h expected %h", {bcd_a, running_a, done_a}, {16'h5959, 1'b1, 1'b0});
        else n_pass++;
        rise_tick();
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h0000, 1'b1, 1'b0})
            $display("FAIL up_wrap: got %h expected %h", {bcd_a, running_a, done_a}, {16'h0000, 1'b1, 1'b0});
        else n_pass++;
        pulse_clear();
    endtask

    task automatic test_down_zero;
        mode = 1'b1;
        pulse_load(16'h0002);
        pulse_start();
        rise_tick();
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h0001, 1'b1, 1'b0})
            $display("FAIL down_0001: got %h expected %h", {bcd_a, running_a, done_a}, {16'h0001, 1'b1, 1'b0});
        else n_pass++;
        rise_tick();
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h0000, 1'b0, 1'b1})
            $display("FAIL down_done: got %h expected %h", {bcd_a, running_a, done_a}, {16'h0000, 1'b0, 1'b1});
        else n_pass++;
        rise_tick();
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h0000, 1'b0, 1'b1})
            $display("FAIL down_hold: got %h expected %h", {bcd_a, running_a, done_a}, {16'h0000, 1'b0, 1'b1});
        else n_pass++;
        pulse_clear();
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL done_clear: got %h expected %h", {bcd_a, running_a, done_a}, 18'h0);
        else n_pass++;
    endtask

    task automatic test_borrow;
        mode = 1'b1;
        tick_src = 1'b0; clk1();
        pulse_load(16'h1000);
        pulse_start();
        tick_src = 1'b1; clk1();
        n_total++;
        if ({bcd_a, bcd_b} !== {16'h0959, 16'h0959})
            $display("FAIL borrow_rise: got %h expected %h", {bcd_a, bcd_b}, {16'h0959, 16'h0959});
        else n_pass++;
        tick_src = 1'b0; clk1();
        n_total++;
        if ({bcd_a, bcd_b} !== {16'h0959, 16'h0958})
            $display("FAIL borrow_fall: got %h expected %h", {bcd_a, bcd_b}, {16'h0959, 16'h0958});
        else n_pass++;
        pulse_clear();
    endtask

    task automatic test_simultaneous;
        mode = 1'b0;
        pulse_load(16'h0010);
        pulse_start();
        stop = 1'b1; tick_src = 1'b1; clk1(); stop = 1'b0;
        n_total++;
        if ({bcd_a, running_a} !== {16'h0011, 1'b0})
            $display("FAIL stop_tick: got %h expected %h", {bcd_a, running_a}, {16'h0011, 1'b0});
        else n_pass++;
        rise_tick();
        n_total++;
        if ({bcd_a, running_a} !== {16'h0011, 1'b0})
            $display("FAIL pause_hold: got %h expected %h", {bcd_a, running_a}, {16'h0011, 1'b0});
        else n_pass++;
        start = 1'b1; stop = 1'b1; clk1(); start = 1'b0; stop = 1'b0;
        n_total++;
        if ({bcd_a, running_a} !== {16'h0011, 1'b0})
            $display("FAIL start_stop_pause: got %h expected %h", {bcd_a, running_a}, {16'h0011, 1'b0});
        else n_pass++;
        pulse_start();
        tick_src = 1'b0; clk1();
        clear = 1'b1; tick_src = 1'b1; clk1(); clear = 1'b0;
        n_total++;
        if ({bcd_a, running_a, done_a} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL clear_tick: got %h expected %h", {bcd_a, running_a, done_a}, 18'h0);
        else n_pass++;
        rise_tick();
        n_total++;
        if ({bcd_a, running_a} !== {16'h0000, 1'b0})
            $display("FAIL clear_idle: got %h expected %h", {bcd_a, running_a}, 17'h0);
        else n_pass++;
    endtask

    task automatic test_bad_load;
        mode = 1'b0;
        pulse_load(16'h0130);
        pulse_load(16'h0a00);
        pulse_load(16'h0070);
        pulse_load(16'h6000);
        n_total++;
        if (bcd_a !== 16'h0130)
            $display("FAIL bad_load: got %h expected %h", bcd_a, 16'h0130);
        else n_pass++;
        pulse_clear();
        mode = 1'b1;
        pulse_start();
        n_total++;
        if ({bcd_a, running_a} !== {16'h0000, 1'b0})
            $display("FAIL down_start_zero: got %h expected %h", {bcd_a, running_a}, 17'h0);
        else n_pass++;
        mode = 1'b0;
        pulse_start();
        n_total++;
        if (running_a !== 1'b1)
            $display("FAIL up_start_zero: got %b expected %b", running_a, 1'b1);
        else n_pass++;
        pulse_clear();
    endtask

    task automatic test_random;
        bit ev0, ev1;
        rst = 1'b1; tick_src = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        load = 1'b0; mode = 1'b0;
        #2 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = S_IDLE; m_total[k] = 0;
        end
        src_last = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) tick_src = ~tick_src;
            clear = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 4) == 0);
            load  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 16'($urandom);
                1:       load_val = to_bcd(int'($urandom_range(0, 130)));
                default: load_val = to_bcd(int'($urandom_range(0, MAX_T)));
            endcase
            if (m_total[0] != 0 && m_total[1] != 0 && $urandom_range(0, 24) == 0) mode = ~mode;
            for (int k = 0; k < 2; k++) begin
                if (m_state[k] == S_IDLE || m_state[k] == S_DONE) stop = 1'b0;
                if (mode && m_total[k] <= 1) stop = 1'b0;
                if (m_state[k] == S_DONE && !valid_bcd(load_val)) load = 1'b0;
            end
            ev0 = tick_src & ~src_last;
            ev1 = tick_src ^ src_last;
            #1;
            n_total++;
            if ({tick_a, tick_b} !== {ev0, ev1})
                $display("FAIL rand_tick[%0d]: got %b expected %b", i, {tick_a, tick_b}, {ev0, ev1});
            else n_pass++;
            model_step(0, ev0);
            model_step(1, ev1);
            src_last = tick_src;
            clk1();
            n_total++;
            if ({bcd_a, running_a, done_a} !== {to_bcd(m_total[0]), m_state[0] == S_RUN, m_state[0] == S_DONE})
                $display("FAIL rand_a[%0d]: got %h expected %h", i, {bcd_a, running_a, done_a},
                         {to_bcd(m_total[0]), m_state[0] == S_RUN, m_state[0] == S_DONE});
            else n_pass++;
            n_total++;
            if ({bcd_b, running_b, done_b} !== {to_bcd(m_total[1]), m_state[1] == S_RUN, m_state[1] == S_DONE})
                $display("FAIL rand_b[%0d]: got %h expected %h", i, {bcd_b, running_b, done_b},
                         {to_bcd(m_total[1]), m_state[1] == S_RUN, m_state[1] == S_DONE});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_zero();
        test_borrow();
        test_simultaneous();
        test_bad_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
